// File: rtl/kbd_scan_ctrl.sv
// Drains the PS/2 receiver FIFO one byte per 3 cycles and turns set-2 scan codes
// into single-cycle key events, with E0/F0 prefix folding and auto-repeat suppression.
module kbd_scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       ps2_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       held_valid,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic [7:0] make_cnt,
  output logic       ovf_flag,
  output logic       err_flag
);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t     state;
  logic [7:0] byte_r;
  logic       ext_pend;
  logic       brk_pend;

  logic is_err;
  logic held_match;

  assign is_err     = (byte_r == 8'h00) || (byte_r == 8'hFF);
  assign held_match = held_valid && (held_code == byte_r) && (held_ext == ext_pend);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      byte_r         <= 8'h00;
      ext_pend       <= 1'b0;
      brk_pend       <= 1'b0;
      ps2_nextdata_n <= 1'b1;
      key_valid      <= 1'b0;
      key_code       <= 8'h00;
      key_ext        <= 1'b0;
      key_release    <= 1'b0;
      held_valid     <= 1'b0;
      held_code      <= 8'h00;
      held_ext       <= 1'b0;
      make_cnt       <= 8'h00;
      ovf_flag       <= 1'b0;
      err_flag       <= 1'b0;
    end else begin
      key_valid <= 1'b0;

      if (ps2_overflow)
        ovf_flag <= 1'b1;
      else if (clr)
        ovf_flag <= 1'b0;

      // A decoded error byte in GAP overrides this clear further down.
      if (clr)
        err_flag <= 1'b0;

      case (state)
        IDLE: begin
          if (en && ps2_ready) begin
            byte_r         <= ps2_data;
            ps2_nextdata_n <= 1'b0;
            state          <= POP;
          end
        end
        POP: begin
          ps2_nextdata_n <= 1'b1;
          state          <= GAP;
        end
        GAP: begin
          state <= IDLE;
          if (byte_r == 8'hE0) begin
            ext_pend <= 1'b1;
          end else if (byte_r == 8'hF0) begin
            brk_pend <= 1'b1;
          end else if (is_err) begin
            err_flag <= 1'b1;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (brk_pend) begin
              key_valid   <= 1'b1;
              key_code    <= byte_r;
              key_ext     <= ext_pend;
              key_release <= 1'b1;
              if (held_match)
                held_valid <= 1'b0;
            end else if (!held_match) begin
              key_valid   <= 1'b1;
              key_code    <= byte_r;
              key_ext     <= ext_pend;
              key_release <= 1'b0;
              make_cnt    <= make_cnt + 8'd1;
              held_valid  <= 1'b1;
              held_code   <= byte_r;
              held_ext    <= ext_pend;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Self-checking bench for kbd_scan_ctrl: emulated receiver FIFO, behavioural reference model,
// per-cycle output compare, directed scenarios plus a randomized run.
module tb_kbd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_overflow;
  logic       ps2_nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       held_valid;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] make_cnt;
  logic       ovf_flag;
  logic       err_flag;

  kbd_scan_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .ps2_data(ps2_data), .ps2_ready(ps2_ready), .ps2_overflow(ps2_overflow),
    .ps2_nextdata_n(ps2_nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_release(key_release), .held_valid(held_valid),
    .held_code(held_code), .held_ext(held_ext), .make_cnt(make_cnt),
    .ovf_flag(ovf_flag), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Receiver FIFO contents and observations of the DUT.
  logic [7:0] fifo[$];
  logic [9:0] ev_log[$];
  int cyc_n, nd_low_cnt, kv_cnt, last_nd_cyc, last_kv_cyc;

  // Reference model state.
  int         stage;
  logic [7:0] cur;
  logic       pext, pbrk;
  logic       x_nd, x_kv, x_rel, x_ext, x_hv, x_he, x_ovf, x_err;
  logic [7:0] x_code, x_hc, x_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    stage = 0; cur = 8'h00; pext = 1'b0; pbrk = 1'b0;
    x_nd = 1'b1; x_kv = 1'b0; x_rel = 1'b0; x_ext = 1'b0; x_code = 8'h00;
    x_hv = 1'b0; x_hc = 8'h00; x_he = 1'b0; x_mc = 8'h00; x_ovf = 1'b0; x_err = 1'b0;
  endtask

  task automatic emit(input logic [7:0] c, input logic e, input logic r);
    x_kv = 1'b1; x_code = c; x_ext = e; x_rel = r;
  endtask

  // What a clock edge must do, given the inputs currently applied.
  task automatic model_edge();
    logic same;
    x_kv = 1'b0;
    if (ps2_overflow) x_ovf = 1'b1;
    else if (clr)     x_ovf = 1'b0;
    if (clr) x_err = 1'b0;
    if (stage == 0) begin
      if (en && ps2_ready) begin
        cur = ps2_data; x_nd = 1'b0; stage = 1;
      end
    end else if (stage == 1) begin
      void'(fifo.pop_front());
      x_nd = 1'b1; stage = 2;
    end else begin
      stage = 0;
      if (cur == 8'hE0) pext = 1'b1;
      else if (cur == 8'hF0) pbrk = 1'b1;
      else if (cur == 8'h00 || cur == 8'hFF) begin
        x_err = 1'b1; pext = 1'b0; pbrk = 1'b0;
      end else begin
        same = x_hv && (x_hc == cur) && (x_he == pext);
        if (pbrk) begin
          emit(cur, pext, 1'b1);
          if (same) x_hv = 1'b0;
        end else if (!same) begin
          emit(cur, pext, 1'b0);
          x_mc = x_mc + 8'd1;
          x_hv = 1'b1; x_hc = cur; x_he = pext;
        end
        pext = 1'b0; pbrk = 1'b0;
      end
    end
  endtask

  task automatic drive_fifo();
    ps2_ready = (fifo.size() != 0);
    ps2_data  = ps2_ready ? fifo[0] : 8'($urandom);
  endtask

  task automatic cyc();
    drive_fifo();
    @(posedge clk);
    model_edge();
    #1;
    cyc_n++;
    chk("nextdata_n", ps2_nextdata_n, x_nd);
    chk("key_valid",  key_valid,  x_kv);
    chk("key_code",   key_code,   x_code);
    chk("key_ext",    key_ext,    x_ext);
    chk("key_release", key_release, x_rel);
    chk("held_valid", held_valid, x_hv);
    chk("held_code",  held_code,  x_hc);
    chk("held_ext",   held_ext,   x_he);
    chk("make_cnt",   make_cnt,   x_mc);
    chk("ovf_flag",   ovf_flag,   x_ovf);
    chk("err_flag",   err_flag,   x_err);
    if (!ps2_nextdata_n) begin nd_low_cnt++; last_nd_cyc = cyc_n; end
    if (key_valid) begin
      kv_cnt++; last_kv_cyc = cyc_n;
      ev_log.push_back({key_ext, key_release, key_code});
    end
    clr = 1'b0;
    ps2_overflow = 1'b0;
  endtask

  task automatic clear_obs();
    ev_log.delete(); nd_low_cnt = 0; kv_cnt = 0; last_nd_cyc = 0; last_kv_cyc = 0;
  endtask

  // Called at posedge+1; reset pulse stays clear of clock edges.
  task automatic hard_reset();
    rst = 1'b1;
    fifo.delete();
    model_reset();
    #2;
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    logic [7:0] v[3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < n; i++) fifo.push_back(v[i]);
  endtask

  task automatic drain();
    int guard = 0;
    while ((fifo.size() != 0 || stage != 0) && guard < 4000) begin
      cyc(); guard++;
    end
    if (guard >= 4000) chk("drain_timeout", 32'd1, 32'd0);
    cyc(); cyc();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; ps2_overflow = 1'b0;
    ps2_ready = 1'b0; ps2_data = 8'h00;
    cyc_n = 0;
    model_reset();
    clear_obs();
    #12;
    chk("rst_nextdata_n", ps2_nextdata_n, 1'b1);
    chk("rst_key_valid",  key_valid, 1'b0);
    chk("rst_make_cnt",   make_cnt, 8'h00);
    chk("rst_held_valid", held_valid, 1'b0);
    rst = 1'b0;

    // 1C, F0 1C
    push3(8'h1C, 8'hF0, 8'h1C, 3);
    drain();
    chk("t1_events", kv_cnt, 2);
    chk("t1_pops", nd_low_cnt, 3);
    chk("t1_latency", last_kv_cyc - last_nd_cyc, 2);
    chk("t1_ev0", ev_log[0], {2'b00, 8'h1C});
    chk("t1_ev1", ev_log[1], {2'b01, 8'h1C});
    chk("t1_make_cnt", make_cnt, 8'd1);
    chk("t1_held", held_valid, 1'b0);

    // E0 75, E0 F0 75
    hard_reset();
    push3(8'hE0, 8'h75, 8'hE0, 3);
    push3(8'hF0, 8'h75, 8'h00, 2);
    drain();
    chk("t2_events", kv_cnt, 2);
    chk("t2_ev0", ev_log[0], {2'b10, 8'h75});
    chk("t2_ev1", ev_log[1], {2'b11, 8'h75});

    // Auto-repeat suppressed
    hard_reset();
    push3(8'h1C, 8'h1C, 8'h1C, 3);
    push3(8'hF0, 8'h1C, 8'h00, 2);
    drain();
    chk("t3_events", kv_cnt, 2);
    chk("t3_make_cnt", make_cnt, 8'd1);

    // Release of a non-held key keeps the held key
    hard_reset();
    push3(8'h1C, 8'h32, 8'hF0, 3);
    fifo.push_back(8'h1C);
    drain();
    chk("t4_events", kv_cnt, 3);
    chk("t4_ev2", ev_log[2], {2'b01, 8'h1C});
    chk("t4_held_valid", held_valid, 1'b1);
    chk("t4_held_code", held_code, 8'h32);
    chk("t4_make_cnt", make_cnt, 8'd2);

    // Error byte drops the pending prefix; flag clear and set-wins
    hard_reset();
    push3(8'hE0, 8'hFF, 8'h1C, 3);
    drain();
    chk("t5_err", err_flag, 1'b1);
    chk("t5_ev0", ev_log[0], {2'b00, 8'h1C});
    clr = 1'b1; cyc();
    chk("t5_err_clr", err_flag, 1'b0);
    ps2_overflow = 1'b1; cyc();
    chk("t5_ovf_set", ovf_flag, 1'b1);
    ps2_overflow = 1'b1; clr = 1'b1; cyc();
    chk("t5_ovf_setwins", ovf_flag, 1'b1);
    clr = 1'b1; cyc();
    chk("t5_ovf_clr", ovf_flag, 1'b0);

    // 256 make/release pairs wrap the make counter
    hard_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = 8'((i % 200) + 1);
      if (i >= 200) fifo.push_back(8'hE0);
      fifo.push_back(c);
      if (i >= 200) fifo.push_back(8'hE0);
      fifo.push_back(8'hF0);
      fifo.push_back(c);
    end
    drain();
    chk("t6_events", kv_cnt, 512);
    chk("t6_make_wrap", make_cnt, 8'd0);

    // en low blocks new pops
    hard_reset();
    en = 1'b0;
    fifo.push_back(8'h2A);
    for (int i = 0; i < 10; i++) cyc();
    chk("t7_no_pop", nd_low_cnt, 0);
    en = 1'b1;
    drain();
    chk("t7_pop_after_en", nd_low_cnt, 1);
    chk("t7_event", ev_log[0], {2'b00, 8'h2A});

    // Asynchronous reset during POP
    hard_reset();
    fifo.push_back(8'h1C);
    drain();
    fifo.push_back(8'h32);
    begin
      int g = 0;
      while (stage != 1 && g < 20) begin cyc(); g++; end
    end
    chk("t8_in_pop", ps2_nextdata_n, 1'b0);
    rst = 1'b1;
    #1;
    chk("t8_nd_released", ps2_nextdata_n, 1'b1);
    chk("t8_zero_outs", {key_valid, key_code, key_ext, key_release, held_valid,
                         held_code, held_ext, make_cnt, ovf_flag, err_flag}, 0);
    fifo.delete();
    model_reset();
    #1;
    rst = 1'b0;
    cyc(); cyc();

    // Randomized traffic
    hard_reset();
    for (int i = 0; i < 4000; i++) begin
      if (fifo.size() < 3) begin
        case ($urandom_range(0, 9))
          0: fifo.push_back(8'hE0);
          1, 2: fifo.push_back(8'hF0);
          3: fifo.push_back($urandom_range(0, 1) ? 8'h00 : 8'hFF);
          4, 5: fifo.push_back(8'h1C);
          6: fifo.push_back(8'h75);
          default: fifo.push_back(8'($urandom));
        endcase
      end
      en = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 40) == 0);
      ps2_overflow = ($urandom_range(0, 60) == 0);
      cyc();
    end
    en = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
